universal_shift_register: RTL
=============================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data register width (>=2).
REQ-002 Parameter AW, default 4, SHALL set the shift-amount width.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 resetp  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL gate all state changes; enable=0 freezes every register except the done pulse (REQ-016).
REQ-006 start  input  1  SHALL be the command strobe, sampled only in IDLE with enable=1.
REQ-007 op  input  3  SHALL select the command: 000 hold, 001 load, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 clear.
REQ-008 amount  input  AW  SHALL give the number of single-bit steps for opcodes 010-110.
REQ-009 d  input  WIDTH  SHALL be the parallel load data.
REQ-010 serial_in  input  1  SHALL be the fill bit for SLL and SRL.
REQ-011 q  output  WIDTH  SHALL be the register contents.
REQ-012 serial_out  output  1  SHALL be the bit most recently shifted or rotated out.
REQ-013 busy  output  1  SHALL be high while a multi-cycle shift is in progress.
REQ-014 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-015 State machine SHALL have two states: IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-016 done SHALL clear on every rising edge not generating a new pulse, regardless of enable.
REQ-017 Accept: at an edge in IDLE with enable=1 and start=1, the command SHALL be accepted; op=000 SHALL be ignored (no done).
REQ-018 Load (001): q<=d at the accept edge; done=1 the following cycle; state stays IDLE.
REQ-019 Clear (111): q<=0 at the accept edge; done=1 the following cycle; serial_out unchanged.
REQ-020 Shift/rotate with amount=0: q unchanged, state stays IDLE, done=1 the following cycle.
REQ-021 Shift/rotate with amount=n>0: accept edge SHALL latch op and n into an internal counter, move to SHIFT, leave q unchanged.
REQ-022 In SHIFT, each edge with enable=1 SHALL perform one step and decrement the counter; the edge performing step n SHALL return to IDLE and set done=1.
REQ-023 With enable held high, busy SHALL be high for exactly n cycles; each enable=0 cycle in SHIFT SHALL extend busy by one cycle with q frozen.
REQ-024 Step definitions: SLL q<={q[W-2:0],serial_in}, serial_out<=q[W-1]; SRL q<={serial_in,q[W-1:1]}, serial_out<=q[0]; SRA q<={q[W-1],q[W-1:1]}, serial_out<=q[0]; ROL q<={q[W-2:0],q[W-1]}, serial_out<=q[W-1]; ROR q<={q[0],q[W-1:1]}, serial_out<=q[0].
REQ-025 Steps SHALL use the op latched at accept; changes on op, amount or d during SHIFT SHALL have no effect.
REQ-026 serial_in SHALL be sampled at each step edge, not latched at accept.
REQ-027 amount > WIDTH SHALL be honoured step by step (logical shifts fully flush to fill; rotates wrap modulo WIDTH).
REQ-028 start while busy=1 SHALL be ignored and not queued.

Reset
REQ-029 resetp=1 SHALL immediately, without a clock edge, force q=0, serial_out=0, busy=0, done=0, counter=0, state IDLE, including mid-SHIFT.
REQ-030 After resetp deasserts, the first accept edge SHALL behave as from IDLE with no residue of the aborted command.

Verification (WIDTH=8, AW=4)
REQ-031 Load: start, op=001, d=0xA5 -> q=0xA5 after one edge, done high one cycle, busy never high.
REQ-032 SLL: from 0xA5, op=010, amount=3, serial_in=1 -> q 0x4B, 0x97, 0x2F on successive edges; busy 3 cycles; serial_out=1; done pulses once.
REQ-033 SRA: from 0x90, op=100, amount=2 -> q 0xC8 then 0xE4; serial_out=0; busy 2 cycles.
REQ-034 ROR: from 0x01, op=110, amount=9 -> q=0x80 after 9 steps; busy 9 cycles; serial_out=1.
REQ-035 Pause: SLL amount=4 with enable=0 for 2 mid-shift cycles and start pulsed during busy -> q frozen while paused, busy 6 cycles, result matches unpaused, start ignored.
REQ-036 Reset: resetp asserted between edges during a 5-step ROL -> q=0, busy=0, done=0 before next edge; following load of 0x3C completes normally.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// ---------------------------------------------------------------------------
// universal_shift_register_if
//   Bundles the command and result signals of the universal shift register.
//   Ports (all members, clock/reset stay outside the bundle):
//     enable      : global state-change gate
//     start       : command strobe, only sampled while idle
//     op[2:0]     : command select (hold/load/SLL/SRL/SRA/ROL/ROR/clear)
//     amount[AW]  : number of single-bit steps for shift/rotate commands
//     d[WIDTH]    : parallel load data
//     serial_in   : fill bit for logical shifts, sampled at every step edge
//     q[WIDTH]    : register contents
//     serial_out  : last bit shifted or rotated out
//     busy        : high while a multi-cycle shift is running
//     done        : one-cycle completion pulse
//   Modports: master drives commands (bench / host), slave is the register.
// ---------------------------------------------------------------------------
interface universal_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             enable;
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amount;
    logic [WIDTH-1:0] d;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, op, amount, d, serial_in,
        input  q, serial_out, busy, done
    );

    modport slave (
        input  enable, start, op, amount, d, serial_in,
        output q, serial_out, busy, done
    );
endinterface

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//   WIDTH-bit register supporting parallel load, clear, and multi-cycle
//   logical/arithmetic shifts and rotates performed one bit per clock.
//   Ports:
//     clock  : single clock, all state changes on its rising edge
//     resetp : asynchronous active-high reset (clears everything at once)
//     bus    : universal_shift_register_if.slave command/result bundle
//   Behaviour summary:
//     IDLE  : a start strobe (with enable) accepts op. Load/clear and
//             zero-length shifts finish at the accept edge and pulse done
//             on the following cycle. Non-zero shifts latch op/amount and
//             move to SHIFT without touching q.
//     SHIFT : one step per enabled edge; the last step returns to IDLE and
//             raises done. New start strobes are ignored here.
//   done is the only flop that ignores enable: it drops on every edge that
//   does not produce a new pulse.
// ---------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic                         clock,
    input  logic                         resetp,
    universal_shift_register_if.slave    bus
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_SRA   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             sout_q,   sout_d;
    logic [AW-1:0]    cnt_q,    cnt_d;
    logic [2:0]       op_q,     op_d;
    logic             done_q,   done_d;

    // -----------------------------------------------------------------------
    // Single-step candidates, one vector per shift flavour, built bit by bit.
    // serial_in feeds the logical shifts live, so a changing fill bit is
    // picked up at each step rather than frozen at accept time.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            // Left-moving flavours: bit gi takes bit gi-1, LSB takes the fill.
            if (gi == 0) begin : g_lsb
                assign sll_v[gi] = bus.serial_in;
                assign rol_v[gi] = data_q[WIDTH-1];
            end else begin : g_lmid
                assign sll_v[gi] = data_q[gi-1];
                assign rol_v[gi] = data_q[gi-1];
            end

            // Right-moving flavours: bit gi takes bit gi+1, MSB takes the fill.
            if (gi == WIDTH-1) begin : g_msb
                assign srl_v[gi] = bus.serial_in;
                assign sra_v[gi] = data_q[WIDTH-1];
                assign ror_v[gi] = data_q[0];
            end else begin : g_rmid
                assign srl_v[gi] = data_q[gi+1];
                assign sra_v[gi] = data_q[gi+1];
                assign ror_v[gi] = data_q[gi+1];
            end
        end
    endgenerate

    // Pick the step result for the op latched at accept time.
    logic [WIDTH-1:0] step_data;
    logic             step_sout;

    always_comb begin
        step_data = data_q;
        step_sout = sout_q;
        case (op_q)
            OP_SLL: begin
                step_data = sll_v;
                step_sout = data_q[WIDTH-1];
            end
            OP_SRL: begin
                step_data = srl_v;
                step_sout = data_q[0];
            end
            OP_SRA: begin
                step_data = sra_v;
                step_sout = data_q[0];
            end
            OP_ROL: begin
                step_data = rol_v;
                step_sout = data_q[WIDTH-1];
            end
            OP_ROR: begin
                step_data = ror_v;
                step_sout = data_q[0];
            end
            default: begin
                step_data = data_q;
                step_sout = sout_q;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;     // pulse: falls on any edge that does not re-raise it

        if (bus.enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_HOLD: begin
                                // ignored command, no completion pulse
                            end
                            OP_LOAD: begin
                                data_d = bus.d;
                                done_d = 1'b1;
                            end
                            OP_CLEAR: begin
                                // serial_out deliberately keeps its value
                                data_d = '0;
                                done_d = 1'b1;
                            end
                            default: begin
                                if (bus.amount == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    op_d    = bus.op;
                                    cnt_d   = bus.amount;
                                    state_d = ST_SHIFT;
                                end
                            end
                        endcase
                    end
                end

                ST_SHIFT: begin
                    data_d = step_data;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - AW'(1);
                    // cnt_q holds the steps still to do, so 1 means this
                    // edge performs the final step.
                    if (cnt_q == AW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.q          = data_q;
    assign bus.serial_out = sout_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = done_q;

endmodule
